// File: rtl/piccolo_stream_io.sv
// Stream front/back end for the Piccolo-128 core: packs two 32-bit words into a block,
// strobes the core load, waits out the fixed run time and returns the ciphertext as two words.
module piccolo_stream_io #(
   parameter int unsigned CORE_LATENCY = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        core_reset,
   output logic [0:63] core_plaintext,
   input  logic [0:63] core_ciphertext,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        busy
);

   localparam int unsigned CNT_W = $clog2(CORE_LATENCY) + 1;

   typedef enum logic [2:0] {
      S_IN0,
      S_IN1,
      S_LOAD,
      S_RUN,
      S_OUT0,
      S_OUT1
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [0:63]        pt_q, pt_d;
   logic [0:63]        ct_q, ct_d;
   logic               load;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pt_d      = pt_q;
      ct_d      = ct_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      load      = 1'b0;

      unique case (state_q)
         S_IN0: begin
            in_ready = 1'b1;
            if (in_valid) begin
               pt_d[0:31] = in_data;
               state_d    = S_IN1;
            end
         end
         S_IN1: begin
            in_ready = 1'b1;
            if (in_valid) begin
               pt_d[32:63] = in_data;
               state_d     = S_LOAD;
            end
         end
         S_LOAD: begin
            load    = 1'b1;
            cnt_d   = CNT_W'(CORE_LATENCY - 1);
            state_d = S_RUN;
         end
         S_RUN: begin
            // Capture lands CORE_LATENCY edges after the load edge.
            if (cnt_q == '0) begin
               ct_d    = core_ciphertext;
               state_d = S_OUT0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_OUT0: begin
            out_valid = 1'b1;
            out_data  = ct_q[0:31];
            if (out_ready) state_d = S_OUT1;
         end
         S_OUT1: begin
            out_valid = 1'b1;
            out_data  = ct_q[32:63];
            if (out_ready) state_d = S_IN0;
         end
         default: state_d = S_IN0;
      endcase

      // Reset forces the idle-facing handshake immediately, not one edge later.
      if (reset) begin
         in_ready  = 1'b1;
         out_valid = 1'b0;
         out_data  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IN0;
         cnt_q   <= '0;
         pt_q    <= '0;
         ct_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pt_q    <= pt_d;
         ct_q    <= ct_d;
      end
   end

   assign core_reset     = reset | load;
   assign core_plaintext = pt_q;
   assign busy           = !reset && (state_q != S_IN0);

endmodule

// File: tb/tb_piccolo_stream_io.sv
// Directed bench for piccolo_stream_io using an XOR stub core that is only valid
// once the full run time has elapsed since its load.
module tb_piccolo_stream_io;

   localparam int unsigned L = 6;
   localparam logic [63:0] KEY = 64'hA5A5_5A5A_0F0F_F0F0;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        core_reset;
   logic [63:0] core_plaintext;
   logic [63:0] core_ciphertext;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   piccolo_stream_io #(.CORE_LATENCY(L)) dut (
      .clk             (clk),
      .reset           (reset),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_data         (in_data),
      .core_reset      (core_reset),
      .core_plaintext  (core_plaintext),
      .core_ciphertext (core_ciphertext),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .busy            (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stub core: garbage until L-1 edges have passed since the load edge.
   logic [63:0] stub_pt;
   int          stub_cnt;
   int          load_cnt;
   initial begin
      stub_pt  = '0;
      stub_cnt = 0;
      load_cnt = 0;
   end
   always @(posedge clk) begin
      if (core_reset) begin
         stub_pt  <= core_plaintext;
         stub_cnt <= 0;
      end else if (stub_cnt < 1000) begin
         stub_cnt <= stub_cnt + 1;
      end
      if (core_reset && !reset) load_cnt <= load_cnt + 1;
   end
   assign core_ciphertext = (stub_cnt >= int'(L) - 1) ? (stub_pt ^ KEY) : 64'hDEAD_BEEF_DEAD_BEEF;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic send_word(input string tag, input logic [31:0] w);
      int n;
      in_valid = 1'b1;
      in_data  = w;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check({tag, "_ready_timeout"}, 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic recv_word(input string tag, input logic [31:0] exp);
      int n;
      out_ready = 1'b1;
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_data"}, 64'(out_data), 64'(exp));
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic pulse_reset(input int cycles);
      reset    = 1'b1;
      in_valid = 1'b0;
      #1;
      check("rst_outs", {60'd0, in_ready, out_valid, busy, core_reset}, {60'd0, 4'b1001});
      check("rst_data", 64'(out_data), 64'd0);
      repeat (cycles) @(negedge clk);
      reset = 1'b0;
   endtask

   logic [63:0] w_pt;
   logic [31:0] words [0:15];
   int          n;
   int          loads0;
   logic        saw_valid;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      @(negedge clk);
      pulse_reset(2);
      #1;
      check("idle_outs", {60'd0, in_ready, out_valid, busy, core_reset}, {60'd0, 4'b1000});
      check("idle_pt", core_plaintext, 64'd0);

      // 1: back-to-back block, load pulse and output latency
      loads0 = load_cnt;
      send_word("t1w0", 32'h0123_4567);
      check("t1_busy_in1", 64'(busy), 64'd1);
      send_word("t1w1", 32'h89AB_CDEF);
      check("t1_load", {62'd0, core_reset, in_ready}, {62'd0, 2'b10});
      check("t1_pt", core_plaintext, 64'h0123_4567_89AB_CDEF);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
         if (n == 1) check("t1_load_1clk", 64'(core_reset), 64'd0);
      end
      check("t1_latency", 64'(n), 64'(L + 1));
      check("t1_load_count", 64'(load_cnt - loads0), 64'd1);

      // 2: stall in S_OUT0 for 10 clocks, junk on the input side
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = 32'hBAD0_0000 + 32'(i);
         #1;
         check("t2_stall", {out_valid, in_ready, busy, 29'd0, out_data},
               {3'b101, 29'd0, 32'hA486_1F3D});
         @(negedge clk);
      end
      in_valid = 1'b0;
      recv_word("t1o0", 32'hA486_1F3D);
      recv_word("t1o1", 32'h86A4_3D1F);
      check("t1_done", {62'd0, out_valid, busy}, 64'd0);

      // 3: in_valid toggling every clock
      for (int i = 0; i < 16; i++) words[i] = 32'h1000_0000 + 32'(i * 32'h0101_0101);
      for (int i = 0; i < 16; i++) begin
         in_valid = (i % 2 == 0);
         in_data  = words[i];
         @(negedge clk);
      end
      in_valid = 1'b0;
      w_pt = {words[0], words[2]};
      check("t3_pt", core_plaintext, w_pt);
      recv_word("t3o0", w_pt[63:32] ^ KEY[63:32]);
      recv_word("t3o1", w_pt[31:0] ^ KEY[31:0]);
      check("t3_pt_hold", core_plaintext, w_pt);

      // 4: reset mid-run, then a fresh block
      send_word("t4w0", 32'h1111_1111);
      send_word("t4w1", 32'h2222_2222);
      repeat (3) @(negedge clk);
      pulse_reset(1);
      #1;
      check("t4_pt_clr", core_plaintext, 64'd0);
      saw_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) saw_valid = 1'b1;
      end
      check("t4_no_out", 64'(saw_valid), 64'd0);
      send_word("t4w2", 32'hFFFF_FFFF);
      send_word("t4w3", 32'h0000_0000);
      recv_word("t4o0", 32'h5A5A_A5A5);
      recv_word("t4o1", 32'h0F0F_F0F0);

      // 5: reset between input words discards the first word
      send_word("t5w0", 32'hAAAA_AAAA);
      check("t5_busy", 64'(busy), 64'd1);
      pulse_reset(1);
      send_word("t5w1", 32'h3333_3333);
      send_word("t5w2", 32'h4444_4444);
      check("t5_pt", core_plaintext, 64'h3333_3333_4444_4444);
      recv_word("t5o0", 32'h3333_3333 ^ KEY[63:32]);
      recv_word("t5o1", 32'h4444_4444 ^ KEY[31:0]);
      check("t5_done", {62'd0, out_valid, in_ready}, 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
